// File: rtl/demo_de0_sys_ram_copier.sv
// Avalon-MM block copier: reads LENGTH words from src and writes them to dst through a small FIFO.
// Optional checksum output is enabled by defining RAM_COPIER_CHECKSUM_EN.
module demo_de0_sys_ram_copier #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [LEN_W-1:0]      length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid
`ifdef RAM_COPIER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state_r;
  logic [ADDR_W-1:0]   src_r;
  logic [ADDR_W-1:0]   dst_r;
  logic [LEN_W-1:0]    len_r;
  logic [LEN_W-1:0]    rd_cnt_r;
  logic [LEN_W-1:0]    wr_cnt_r;
  logic [CNT_W-1:0]    outst_r;
  logic [CNT_W-1:0]    fifo_cnt_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [DATA_W-1:0]   fifo_mem_r [FIFO_DEPTH];

  logic                cmd_pending_s;
  logic                rd_acc_s;
  logic                wr_acc_s;
  logic                push_s;
  logic                pop_s;
  logic [CNT_W:0]      credit_s;
  logic                issue_wr_s;
  logic                issue_rd_s;
  logic                last_wr_s;

  assign cmd_pending_s = m_read | m_write;
  assign rd_acc_s      = m_read & ~m_waitrequest;
  assign wr_acc_s      = m_write & ~m_waitrequest;
  // Data arriving with nothing outstanding (e.g. left over from before a reset) is dropped.
  assign push_s        = m_readdatavalid & (outst_r != CNT_ZERO);
  assign pop_s         = wr_acc_s;
  assign credit_s      = {1'b0, fifo_cnt_r} + {1'b0, outst_r};
  assign issue_wr_s    = (state_r == ST_RUN) & ~cmd_pending_s & (fifo_cnt_r != CNT_ZERO);
  assign issue_rd_s    = (state_r == ST_RUN) & ~cmd_pending_s & (fifo_cnt_r == CNT_ZERO)
                       & (rd_cnt_r < len_r) & (credit_s < DEPTH_C);
  assign last_wr_s     = wr_acc_s & ((wr_cnt_r + LEN_W'(1)) == len_r);

  // Control FSM, bus command registers and copy counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      m_address    <= {ADDR_W{1'b0}};
      m_read       <= 1'b0;
      m_write      <= 1'b0;
      m_writedata  <= {DATA_W{1'b0}};
      m_byteenable <= {(DATA_W/8){1'b0}};
      src_r        <= {ADDR_W{1'b0}};
      dst_r        <= {ADDR_W{1'b0}};
      len_r        <= {LEN_W{1'b0}};
      rd_cnt_r     <= {LEN_W{1'b0}};
      wr_cnt_r     <= {LEN_W{1'b0}};
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            src_r    <= src_addr;
            dst_r    <= dst_addr;
            len_r    <= length;
            rd_cnt_r <= {LEN_W{1'b0}};
            wr_cnt_r <= {LEN_W{1'b0}};
            if (length != {LEN_W{1'b0}}) begin
              state_r <= ST_RUN;
              busy    <= 1'b1;
            end else begin
              state_r <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (rd_acc_s) begin
            m_read   <= 1'b0;
            src_r    <= src_r + ADDR_W'(1);
            rd_cnt_r <= rd_cnt_r + LEN_W'(1);
          end
          if (wr_acc_s) begin
            m_write      <= 1'b0;
            m_byteenable <= {(DATA_W/8){1'b0}};
            dst_r        <= dst_r + ADDR_W'(1);
            wr_cnt_r     <= wr_cnt_r + LEN_W'(1);
          end
          if (last_wr_s) begin
            state_r <= ST_DONE;
          end
          // Writes drain the FIFO before any further read is launched.
          if (issue_wr_s) begin
            m_write      <= 1'b1;
            m_address    <= dst_r;
            m_writedata  <= fifo_mem_r[rd_ptr_r];
            m_byteenable <= {(DATA_W/8){1'b1}};
          end else if (issue_rd_s) begin
            m_read    <= 1'b1;
            m_address <= src_r;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Read-data FIFO and in-flight read accounting.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      fifo_cnt_r <= CNT_ZERO;
      outst_r    <= CNT_ZERO;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= m_readdata;
        wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
        2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
      case ({rd_acc_s, push_s})
        2'b10:   outst_r <= outst_r + CNT_W'(1);
        2'b01:   outst_r <= outst_r - CNT_W'(1);
        default: outst_r <= outst_r;
      endcase
    end
  end

`ifdef RAM_COPIER_CHECKSUM_EN
  // Running sum of every word written during the current copy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      checksum <= 32'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      checksum <= 32'd0;
    end else if (wr_acc_s) begin
      checksum <= checksum + m_writedata[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_demo_de0_sys_ram_copier.sv
// Self-checking bench for demo_de0_sys_ram_copier: RAM slave model plus address/data scoreboard.
module tb_demo_de0_sys_ram_copier;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [10:0] src_addr, dst_addr;
  logic [11:0] length;
  logic        busy, done;
  logic [10:0] m_address;
  logic        m_read, m_write;
  logic [31:0] m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest = 1'b0;
  logic [31:0] m_readdata = 32'd0;
  logic        m_readdatavalid = 1'b0;
`ifdef RAM_COPIER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  demo_de0_sys_ram_copier dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid)
`ifdef RAM_COPIER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; int due; } rd_t;

  logic [31:0] ram [0:2047];
  rd_t         pipe [$];
  logic [10:0] rd_exp [$];
  logic [10:0] wa_exp [$];
  logic [31:0] wd_exp [$];

  int vectors = 0, miscompares = 0;
  int wait_pct = 0, lat = 1, cyc = 0;
  int outs = 0, max_outs = 0;
  int rd_seen = 0, wr_seen = 0, done_cnt = 0, cmd_cycles = 0;
  int stab_err = 0, be_err = 0, busy_err = 0, pulse_err = 0;
  logic [31:0] exp_sum = 32'd0;
  int d0, r0, w0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model and monitor: everything is decided on the falling edge for the next rising edge.
  initial begin : slave
    logic        prev_stall, prev_done;
    logic [44:0] prev_cmd;
    logic [10:0] ea;
    logic [31:0] d;
    rd_t         ent;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_cmd   = 45'd0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!reset_n) begin
        outs = 0;
        prev_stall = 1'b0;
        prev_done = 1'b0;
        m_readdatavalid = 1'b0;
        m_waitrequest = 1'b0;
        continue;
      end
      m_waitrequest = (wait_pct > 0) && ($urandom_range(99) < wait_pct);
      if (prev_stall && ({m_read, m_write, m_address, m_writedata} != prev_cmd)) stab_err++;
      prev_stall = (m_read | m_write) & m_waitrequest;
      prev_cmd   = {m_read, m_write, m_address, m_writedata};
      if (m_read | m_write) cmd_cycles++;
      if (m_write ? (m_byteenable != 4'hF) : (m_byteenable != 4'h0)) be_err++;
      if (pipe.size() > 0 && pipe[0].due <= cyc) begin
        m_readdatavalid = 1'b1;
        m_readdata = pipe[0].data;
        void'(pipe.pop_front());
        if (outs > 0) outs--;
      end else begin
        m_readdatavalid = 1'b0;
        m_readdata = $urandom;
      end
      if (m_read && !m_waitrequest) begin
        rd_seen++;
        if (rd_exp.size() == 0) check_eq("rd_extra", 64'd1, 64'd0);
        else begin
          ea = rd_exp.pop_front();
          check_eq("rd_addr", {53'd0, m_address}, {53'd0, ea});
          wd_exp.push_back(ram[ea]);
        end
        ent.data = ram[m_address];
        ent.due  = cyc + lat;
        pipe.push_back(ent);
        outs++;
        if (outs > max_outs) max_outs = outs;
      end
      if (m_write && !m_waitrequest) begin
        wr_seen++;
        if (wa_exp.size() == 0 || wd_exp.size() == 0) check_eq("wr_extra", 64'd1, 64'd0);
        else begin
          ea = wa_exp.pop_front();
          d  = wd_exp.pop_front();
          check_eq("wr_addr", {53'd0, m_address}, {53'd0, ea});
          check_eq("wr_data", {32'd0, m_writedata}, {32'd0, d});
          exp_sum = exp_sum + d;
        end
        ram[m_address] = m_writedata;
      end
      if (done) begin
        done_cnt++;
        if (busy) busy_err++;
        if (prev_done) pulse_err++;
      end
      prev_done = done;
    end
  end

  task automatic start_copy(input logic [10:0] s, input logic [10:0] dd, input int len,
                            input int wpct, input int latency);
    wait_pct = wpct;
    lat = latency;
    for (int i = 0; i < len; i++) begin
      rd_exp.push_back(s + 11'(i));
      wa_exp.push_back(dd + 11'(i));
    end
    exp_sum = 32'd0;
    d0 = done_cnt; r0 = rd_seen; w0 = wr_seen;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = dd; length = 12'(len);
    @(negedge clk);
    start = 1'b0;
    check_eq("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  task automatic finish_copy(input string tag, input int len);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_timeout"}, {63'd0, (done_cnt == d0)}, 64'd0);
    repeat (4) @(negedge clk);
    check_eq({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    check_eq({tag, "_reads"}, 64'(rd_seen - r0), 64'(len));
    check_eq({tag, "_writes"}, 64'(wr_seen - w0), 64'(len));
    check_eq({tag, "_sb_empty"}, 64'(rd_exp.size() + wa_exp.size() + wd_exp.size()), 64'd0);
    check_eq({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    check_eq({tag, "_protocol_errs"}, 64'(stab_err + be_err + busy_err + pulse_err), 64'd0);
    check_eq({tag, "_outs_over_cap"}, {63'd0, (max_outs > 4)}, 64'd0);
`ifdef RAM_COPIER_CHECKSUM_EN
    check_eq({tag, "_checksum"}, {32'd0, checksum}, {32'd0, exp_sum});
`endif
  endtask

  initial begin : stim
    int c0, n;
    reset_n = 1'b0; start = 1'b0;
    src_addr = 11'd0; dst_addr = 11'd0; length = 12'd0;
    for (int i = 0; i < 2048; i++) ram[i] = $urandom;
    for (int i = 0; i < 8; i++) ram[16 + i] = 32'h11111111 * 32'(i + 1);
    repeat (3) @(negedge clk);
    check_eq("reset_state", {busy, done, m_read, m_write, m_address, m_byteenable, m_writedata},
             64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic copy, zero-wait slave, latency 1.
    start_copy(11'h010, 11'h100, 8, 0, 1);
    finish_copy("basic", 8);
    for (int i = 0; i < 8; i++)
      check_eq("basic_ram", {32'd0, ram[11'h100 + 11'(i)]}, {32'd0, 32'h11111111 * 32'(i + 1)});
`ifdef RAM_COPIER_CHECKSUM_EN
    check_eq("basic_checksum_const", {32'd0, checksum}, {32'd0, 32'h66666664});
`endif

    // Zero length: done two cycles after start, no bus traffic, busy never set.
    c0 = cmd_cycles; d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; src_addr = 11'h050; dst_addr = 11'h060; length = 12'd0;
    @(negedge clk);
    start = 1'b0;
    check_eq("len0_first", {62'd0, done, busy}, 64'd0);
    @(negedge clk);
    check_eq("len0_done", {62'd0, done, busy}, 64'd2);
    repeat (3) @(negedge clk);
    check_eq("len0_no_cmds", 64'(cmd_cycles - c0), 64'd0);
    check_eq("len0_pulses", 64'(done_cnt - d0), 64'd1);

    // Backpressure: random stalls, latency 3.
    start_copy(11'h200, 11'h300, 16, 50, 3);
    finish_copy("bp", 16);

    // Address wrap at the top of the 11-bit space.
    start_copy(11'h7FE, 11'h7FF, 4, 0, 1);
    finish_copy("wrap", 4);

    // A second start during the copy must be ignored.
    start_copy(11'h040, 11'h140, 6, 30, 2);
    repeat (5) @(negedge clk);
    start = 1'b1; src_addr = 11'h400; dst_addr = 11'h500; length = 12'd3;
    @(negedge clk);
    start = 1'b0;
    finish_copy("busy_start", 6);

    // Reset after three writes: outputs clear at once, no done, then a clean copy.
    start_copy(11'h020, 11'h180, 8, 0, 1);
    n = 0;
    while ((wr_seen - w0) < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst_wait_timeout", {63'd0, ((wr_seen - w0) < 3)}, 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_eq("midop_reset", {busy, done, m_read, m_write, m_address, m_byteenable, m_writedata},
                64'd0);
    rd_exp.delete(); wa_exp.delete(); wd_exp.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check_eq("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
    start_copy(11'h020, 11'h180, 8, 0, 1);
    finish_copy("post_reset", 8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
